// File: rtl/rpn_stack.sv
// RPN operand stack that feeds an external combinational ALU: push, or pop two operands and push the result.
// Optional build macro RPN_DIV0_CHECK_EN rejects AC_DI/AC_RM operates whose top entry is zero.

`ifndef AC_N
`define AC_N  3
`define AC_AD 3'd0
`define AC_SB 3'd1
`define AC_MU 3'd2
`define AC_DI 3'd3
`define AC_RM 3'd4
`endif

module rpn_stack #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_op,
    input  logic signed [N-1:0]   in_data,
    input  logic [`AC_N-1:0]      in_cmd,
    input  logic                  clr_err,
    output logic signed [N-1:0]   alu_A,
    output logic signed [N-1:0]   alu_B,
    output logic [`AC_N-1:0]      alu_cmd,
    input  logic signed [N-1:0]   alu_C,
    output logic signed [N-1:0]   top,
    output logic [DW-1:0]         depth,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic {IDLE, EXEC} state_e;
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_UNF  = 2'b01,
        ERR_OVF  = 2'b10,
        ERR_DIV0 = 2'b11
    } err_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic                 err_q, err_d;
    err_e                 code_q, code_d;
    logic signed [N-1:0]  a_q, a_d;
    logic signed [N-1:0]  b_q, b_d;
    logic [`AC_N-1:0]     cmd_q, cmd_d;
    logic signed [N-1:0]  stack_q [DEPTH];

    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic signed [N-1:0]  wr_data;
    err_e                 new_err;
    logic [IW-1:0]        idx_a;
    logic [IW-1:0]        idx_b;
    logic signed [N-1:0]  top_c;

    // Operand slots: A is second-from-top, B is top.
    assign idx_a = IW'(depth_q - DW'(2));
    assign idx_b = IW'(depth_q - DW'(1));
    assign top_c = (depth_q == '0) ? '0 : stack_q[idx_b];

    assign in_ready = (state_q == IDLE) && !rst;
    assign top      = top_c;
    assign depth    = depth_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign alu_A    = a_q;
    assign alu_B    = b_q;
    assign alu_cmd  = cmd_q;

    // Next-state: request decode in IDLE, ALU write-back in EXEC, sticky error update.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        err_d   = err_q;
        code_d  = code_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        new_err = ERR_NONE;

        if (clr_err) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!in_op) begin
                        if (depth_q < DW'(DEPTH)) begin
                            wr_en   = 1'b1;
                            wr_idx  = IW'(depth_q);
                            wr_data = in_data;
                            depth_d = depth_q + DW'(1);
                        end else begin
                            new_err = ERR_OVF;
                        end
                    end else if (depth_q < DW'(2)) begin
                        new_err = ERR_UNF;
                    end
`ifdef RPN_DIV0_CHECK_EN
                    else if (((in_cmd == `AC_DI) || (in_cmd == `AC_RM)) && (top_c == '0)) begin
                        new_err = ERR_DIV0;
                    end
`endif
                    else begin
                        a_d     = stack_q[idx_a];
                        b_d     = stack_q[idx_b];
                        cmd_d   = in_cmd;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                wr_en   = 1'b1;
                wr_idx  = idx_a;
                wr_data = alu_C;
                depth_d = depth_q - DW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new error takes precedence over a same-cycle clear.
        if (new_err != ERR_NONE) begin
            err_d  = 1'b1;
            code_d = new_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            code_q  <= code_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
        end
    end

    // Stack storage needs no reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            stack_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack; the bench also models the combinational ALU on alu_A/alu_B/alu_cmd.

`ifndef AC_N
`define AC_N  3
`define AC_AD 3'd0
`define AC_SB 3'd1
`define AC_MU 3'd2
`define AC_DI 3'd3
`define AC_RM 3'd4
`endif

module tb_rpn_stack;

    localparam int unsigned N     = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_op;
    logic signed [N-1:0]  in_data;
    logic [`AC_N-1:0]     in_cmd;
    logic                 clr_err;
    logic signed [N-1:0]  alu_A;
    logic signed [N-1:0]  alu_B;
    logic [`AC_N-1:0]     alu_cmd;
    logic signed [N-1:0]  alu_C;
    logic signed [N-1:0]  top;
    logic [DW-1:0]        depth;
    logic                 err;
    logic [1:0]           err_code;

    int checks = 0;
    int errors = 0;

    rpn_stack #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .in_cmd   (in_cmd),
        .clr_err  (clr_err),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_cmd  (alu_cmd),
        .alu_C    (alu_C),
        .top      (top),
        .depth    (depth),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Reference ALU; division by zero yields 0.
    always_comb begin
        case (alu_cmd)
            `AC_AD:  alu_C = alu_A + alu_B;
            `AC_SB:  alu_C = alu_A - alu_B;
            `AC_MU:  alu_C = alu_A * alu_B;
            `AC_DI:  alu_C = (alu_B == '0) ? '0 : alu_A / alu_B;
            `AC_RM:  alu_C = (alu_B == '0) ? '0 : alu_A % alu_B;
            default: alu_C = '0;
        endcase
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 1'b0;
        in_data  = '0;
        in_cmd   = '0;
        clr_err  = 1'b0;
        tick();
        check("ready_in_rst", 16'(in_ready), 16'd0);
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input logic signed [N-1:0] v);
        check("push_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_op    = 1'b0;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic operate(input logic [`AC_N-1:0] cmd);
        check("op_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_op    = 1'b1;
        in_cmd   = cmd;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_depth", 16'(depth), 16'd0);
        check("rst_top", 16'(top), 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_code", 16'(err_code), 16'd0);
        check("rst_aluA", 16'(alu_A), 16'd0);
        check("rst_aluB", 16'(alu_B), 16'd0);
        check("rst_alucmd", 16'(alu_cmd), 16'd0);
        check("rst_ready", 16'(in_ready), 16'd1);

        // 7 - 3
        push(16'sd7);
        check("p7_top", 16'(top), 16'd7);
        push(16'sd3);
        check("p3_depth", 16'(depth), 16'd2);
        operate(`AC_SB);
        check("sb_busy", 16'(in_ready), 16'd0);
        check("sb_aluA", 16'(alu_A), 16'd7);
        check("sb_aluB", 16'(alu_B), 16'd3);
        check("sb_cmd", 16'(alu_cmd), 16'(`AC_SB));
        tick();
        check("sb_top", 16'(top), 16'd4);
        check("sb_depth", 16'(depth), 16'd1);
        check("sb_err", 16'(err), 16'd0);
        check("sb_ready", 16'(in_ready), 16'd1);
        tick();
        check("hold_aluA", 16'(alu_A), 16'd7);
        check("hold_cmd", 16'(alu_cmd), 16'(`AC_SB));

        // -5 * 6
        do_reset();
        push(-16'sd5);
        push(16'sd6);
        operate(`AC_MU);
        check("mu_busy", 16'(in_ready), 16'd0);
        tick();
        check("mu_ready", 16'(in_ready), 16'd1);
        check("mu_top", 16'(top), 16'hFFE2);
        check("mu_depth", 16'(depth), 16'd1);

        // Underflow, then clear
        do_reset();
        push(16'sd1);
        operate(`AC_AD);
        check("unf_ready", 16'(in_ready), 16'd1);
        check("unf_err", 16'(err), 16'd1);
        check("unf_code", 16'(err_code), 16'd1);
        check("unf_depth", 16'(depth), 16'd1);
        check("unf_top", 16'(top), 16'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", 16'(err), 16'd0);
        check("clr_code", 16'(err_code), 16'd0);

        // Overflow on the ninth push
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            push(16'(i));
        end
        check("ovf_depth", 16'(depth), 16'd8);
        check("ovf_top", 16'(top), 16'd8);
        check("ovf_err", 16'(err), 16'd1);
        check("ovf_code", 16'(err_code), 16'd2);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", 16'(err), 16'd0);
        clr_err = 1'b1;
        push(16'sd10);
        clr_err = 1'b0;
        check("newerr_wins_err", 16'(err), 16'd1);
        check("newerr_wins_code", 16'(err_code), 16'd2);
        check("ovf_top_kept", 16'(top), 16'd8);
        operate(`AC_AD);
        tick();
        check("after_err_top", 16'(top), 16'd15);
        check("after_err_depth", 16'(depth), 16'd7);
        check("sticky_err", 16'(err), 16'd1);

        // Divide / remainder with zero top
        do_reset();
        push(16'sd9);
        push(16'sd0);
        operate(`AC_DI);
`ifdef RPN_DIV0_CHECK_EN
        check("div0_ready", 16'(in_ready), 16'd1);
        check("div0_code", 16'(err_code), 16'd3);
        check("div0_depth", 16'(depth), 16'd2);
        check("div0_top", 16'(top), 16'd0);
        push(16'sd2);
        operate(`AC_RM);
        tick();
        check("rm_top", 16'(top), 16'd0);
        check("rm_depth", 16'(depth), 16'd2);
`else
        check("div_busy", 16'(in_ready), 16'd0);
        tick();
        check("div_code", 16'(err_code), 16'd0);
        check("div_depth", 16'(depth), 16'd1);
        check("div_top", 16'(top), 16'd0);
        push(16'sd2);
        operate(`AC_RM);
        tick();
        check("rm_top", 16'(top), 16'd0);
        check("rm_depth", 16'(depth), 16'd1);
`endif

        // Reset while in EXEC discards the operation
        do_reset();
        push(16'sd4);
        push(16'sd2);
        operate(`AC_DI);
        check("exec_busy", 16'(in_ready), 16'd0);
        rst = 1'b1;
        tick();
        check("exrst_ready", 16'(in_ready), 16'd0);
        check("exrst_depth", 16'(depth), 16'd0);
        check("exrst_top", 16'(top), 16'd0);
        check("exrst_aluA", 16'(alu_A), 16'd0);
        check("exrst_cmd", 16'(alu_cmd), 16'd0);
        rst = 1'b0;
        #1;
        check("exrst_ready_after", 16'(in_ready), 16'd1);
        tick();
        check("exrst_depth_after", 16'(depth), 16'd0);
        check("exrst_top_after", 16'(top), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
